// File: rtl/hazard_scoreboard_ctrl.sv
// rtl/hazard_scoreboard_ctrl.sv - register scoreboard with multi-cycle multiply tracking
// Optional macro WB_BYPASS_EN: hazards on registers cleared this cycle do not stall.
module hazard_scoreboard_ctrl #(
  parameter int MUL_LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ID_Valid,
  input  logic [2:0] ID_RS,
  input  logic [2:0] ID_RT,
  input  logic [2:0] ID_RD,
  input  logic       ID_RegWrite,
  input  logic       ID_IsMul,
  input  logic [2:0] WB_RD,
  input  logic       WB_RegWrite,
  output logic       PC_Hold,
  output logic       IF_ID_Hold,
  output logic       ID_EX_Flush,
  output logic       Mul_Done,
  output logic [2:0] Mul_RD,
  output logic       Mul_Busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] RELOAD = 4'(MUL_LAT - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [2:0] mul_rd_nxt;
  logic [7:0] pending, pending_nxt;
  logic [7:0] set_vec, clr_vec, hazard_vec;
  logic       raw, waw, structural, stall, issue, mul_issue;

  assign Mul_Busy = (state == BUSY);
  assign Mul_Done = (state == BUSY) && (cnt == 4'd0);

  always_comb begin
    clr_vec = '0;
    if (WB_RegWrite) clr_vec[WB_RD] = 1'b1;
    if (Mul_Done)    clr_vec[Mul_RD] = 1'b1;
  end

`ifdef WB_BYPASS_EN
  assign hazard_vec = pending & ~clr_vec;
`else
  assign hazard_vec = pending;
`endif

  // pending[0] is held at zero, so register 0 never produces a hit here.
  assign raw        = hazard_vec[ID_RS] | hazard_vec[ID_RT];
  assign waw        = (ID_RegWrite | ID_IsMul) & hazard_vec[ID_RD] & (ID_RD != 3'd0);
  assign structural = ID_IsMul & Mul_Busy & ~Mul_Done;
  assign stall      = ID_Valid & (raw | waw | structural);
  assign issue      = ID_Valid & ~stall;
  assign mul_issue  = issue & ID_IsMul;

  assign PC_Hold     = stall;
  assign IF_ID_Hold  = stall;
  assign ID_EX_Flush = stall;

  always_comb begin
    set_vec = '0;
    if (issue && (ID_RegWrite || ID_IsMul) && (ID_RD != 3'd0)) set_vec[ID_RD] = 1'b1;
    // A set applied after the clear lets a same-cycle set win.
    pending_nxt    = (pending & ~clr_vec) | set_vec;
    pending_nxt[0] = 1'b0;
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mul_rd_nxt = Mul_RD;
    case (state)
      IDLE: begin
        if (mul_issue) begin
          state_nxt  = BUSY;
          cnt_nxt    = RELOAD;
          mul_rd_nxt = ID_RD;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          if (mul_issue) begin
            cnt_nxt    = RELOAD;
            mul_rd_nxt = ID_RD;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      Mul_RD  <= 3'd0;
      pending <= 8'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      Mul_RD  <= mul_rd_nxt;
      pending <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// tb/tb_hazard_scoreboard_ctrl.sv - directed vector bench for hazard_scoreboard_ctrl
// Expected stall values follow WB_BYPASS_EN when it is defined.
module tb_hazard_scoreboard_ctrl;

  localparam int MUL_LAT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ID_Valid = 1'b0;
  logic [2:0] ID_RS = '0, ID_RT = '0, ID_RD = '0;
  logic       ID_RegWrite = 1'b0, ID_IsMul = 1'b0;
  logic [2:0] WB_RD = '0;
  logic       WB_RegWrite = 1'b0;
  logic       PC_Hold, IF_ID_Hold, ID_EX_Flush, Mul_Done, Mul_Busy;
  logic [2:0] Mul_RD;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .ID_Valid(ID_Valid), .ID_RS(ID_RS), .ID_RT(ID_RT),
    .ID_RD(ID_RD), .ID_RegWrite(ID_RegWrite), .ID_IsMul(ID_IsMul),
    .WB_RD(WB_RD), .WB_RegWrite(WB_RegWrite), .PC_Hold(PC_Hold),
    .IF_ID_Hold(IF_ID_Hold), .ID_EX_Flush(ID_EX_Flush), .Mul_Done(Mul_Done),
    .Mul_RD(Mul_RD), .Mul_Busy(Mul_Busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, v;
    logic [2:0] rs, rt, rd;
    logic       rw, mul;
    logic [2:0] wbrd;
    logic       wbwe;
    logic       st, stb, dn, bs;
    logic [2:0] mrd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic v, logic [2:0] rs, logic [2:0] rt, logic [2:0] rd,
                              logic rw, logic mul, logic [2:0] wbrd, logic wbwe,
                              logic st, logic stb, logic dn, logic bs, logic [2:0] mrd);
    vec_t t;
    t.rst = r; t.v = v; t.rs = rs; t.rt = rt; t.rd = rd; t.rw = rw; t.mul = mul;
    t.wbrd = wbrd; t.wbwe = wbwe; t.st = st; t.stb = stb; t.dn = dn; t.bs = bs; t.mrd = mrd;
    return t;
  endfunction

  task automatic drive(logic r, logic v, logic [2:0] rs, logic [2:0] rt, logic [2:0] rd,
                       logic rw, logic mul, logic [2:0] wbrd, logic wbwe);
    rst = r; ID_Valid = v; ID_RS = rs; ID_RT = rt; ID_RD = rd;
    ID_RegWrite = rw; ID_IsMul = mul; WB_RD = wbrd; WB_RegWrite = wbwe;
  endtask

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] stall_bus();
    return {PC_Hold, IF_ID_Hold, ID_EX_Flush};
  endfunction

  initial begin
    int n, nst;
    logic exp_st;

    //        rst v rs rt rd rw mul wbrd wbwe | st stb dn bs mrd
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0));  // reset state
    vecs.push_back(mk(0,1,0,0,3,1,0,0,0, 0,0,0,0,0));  // write r3
    vecs.push_back(mk(0,1,3,0,4,1,0,0,0, 1,1,0,0,0));  // RAW on r3
    vecs.push_back(mk(0,1,3,0,4,1,0,0,0, 1,1,0,0,0));
    vecs.push_back(mk(0,1,3,0,4,1,0,3,1, 1,0,0,0,0));  // WB of r3
    vecs.push_back(mk(0,1,3,0,4,1,0,0,0, 0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,4,1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,1,0,0,0, 0,0,0,0,0));  // r0 writes never stall
    vecs.push_back(mk(0,1,0,0,0,1,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,1,0,0, 0,0,0,0,0));  // multiply to r0
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,1,0));
    vecs.push_back(mk(0,1,0,0,0,1,0,0,0, 0,0,0,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,5,0,1,0,0, 0,0,0,0,0));  // multiply r5
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,1,5));
    vecs.push_back(mk(0,1,5,0,0,0,0,0,0, 1,1,0,1,5));
    vecs.push_back(mk(0,1,5,0,0,0,0,0,0, 1,0,1,1,5));  // completion cycle
    vecs.push_back(mk(0,1,5,0,0,0,0,0,0, 0,0,0,0,5));
    vecs.push_back(mk(0,1,0,0,6,0,1,0,0, 0,0,0,0,5));  // back-to-back multiplies
    vecs.push_back(mk(0,1,0,0,7,0,1,0,0, 1,1,0,1,6));
    vecs.push_back(mk(0,1,0,0,7,0,1,0,0, 1,1,0,1,6));
    vecs.push_back(mk(0,1,0,0,7,0,1,0,0, 0,0,1,1,6));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,1,7));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,1,7));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,1,1,7));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,7));
    vecs.push_back(mk(0,1,6,7,0,0,0,0,0, 0,0,0,0,7));
    vecs.push_back(mk(0,1,0,0,2,1,0,2,1, 0,0,0,0,7));  // set wins over WB clear
    vecs.push_back(mk(0,1,2,0,0,0,0,0,0, 1,1,0,0,7));
    vecs.push_back(mk(0,0,0,0,0,0,0,2,1, 0,0,0,0,7));
    vecs.push_back(mk(0,1,2,0,0,0,0,0,0, 0,0,0,0,7));
    vecs.push_back(mk(0,1,0,0,1,1,0,0,0, 0,0,0,0,7));  // RAW via RT
    vecs.push_back(mk(0,1,0,1,0,0,0,0,0, 1,1,0,0,7));
    vecs.push_back(mk(0,0,1,0,0,0,0,1,1, 0,0,0,0,7));
    vecs.push_back(mk(0,1,0,0,5,0,1,0,0, 0,0,0,0,7));  // reset abandons multiply
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,1,5));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,5,5,0,0,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,3,1,0,0,0, 0,0,0,0,0));  // WAW from a multiply
    vecs.push_back(mk(0,1,0,0,3,0,1,0,0, 1,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,3,1, 0,0,0,0,0));

    repeat (2) @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].rd,
            vecs[i].rw, vecs[i].mul, vecs[i].wbrd, vecs[i].wbwe);
      #1;
`ifdef WB_BYPASS_EN
      exp_st = vecs[i].stb;
`else
      exp_st = vecs[i].st;
`endif
      check($sformatf("v%0d stall", i), {5'd0, stall_bus()}, {5'd0, {3{exp_st}}});
      check($sformatf("v%0d done", i), {7'd0, Mul_Done}, {7'd0, vecs[i].dn});
      check($sformatf("v%0d busy", i), {7'd0, Mul_Busy}, {7'd0, vecs[i].bs});
      check($sformatf("v%0d mul_rd", i), {5'd0, Mul_RD}, {5'd0, vecs[i].mrd});
    end

    // Multiply latency measured with a bounded wait
    @(negedge clk);
    drive(0,1,0,0,4,0,1,0,0);
    #1;
    check("lat issue stall", {5'd0, stall_bus()}, 8'd0);
    n = 0;
    do begin
      @(negedge clk);
      drive(0,0,0,0,0,0,0,0,0);
      n++;
      #1;
    end while (!Mul_Done && n < 20);
    check("lat cycles", 8'(n), 8'(MUL_LAT));
    check("lat mul_rd", {5'd0, Mul_RD}, 8'd4);
    @(negedge clk);
    #1;
    check("lat done once", {7'd0, Mul_Done}, 8'd0);

    // RAW stall persists for a random number of cycles until writeback
    @(negedge clk);
    drive(0,1,0,0,3,1,0,0,0);
    nst = $urandom_range(2, 6);
    for (int k = 0; k < nst; k++) begin
      @(negedge clk);
      drive(0,1,3,0,0,0,0,0,0);
      #1;
      check($sformatf("hold%0d stall", k), {5'd0, stall_bus()}, 8'h07);
    end
    @(negedge clk);
    drive(0,1,3,0,0,0,0,3,1);
    #1;
`ifdef WB_BYPASS_EN
    check("wb cycle stall", {5'd0, stall_bus()}, 8'h00);
`else
    check("wb cycle stall", {5'd0, stall_bus()}, 8'h07);
`endif
    @(negedge clk);
    drive(0,1,3,0,0,0,0,0,0);
    #1;
    check("after wb stall", {5'd0, stall_bus()}, 8'h00);

    @(negedge clk);
    drive(0,0,0,0,0,0,0,0,0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
